// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit SRAM between the fetch (A)
// and load/store (B) ports, with 1-cycle read response routing.
module sram_arbiter #(
  parameter int AWIDTH = 12
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              A_REQ,
  input  logic [AWIDTH-1:0] A_ADDR,
  input  logic              A_WE,
  input  logic [3:0]        A_BE,
  input  logic [31:0]       A_WDATA,
  input  logic              B_REQ,
  input  logic [AWIDTH-1:0] B_ADDR,
  input  logic              B_WE,
  input  logic [3:0]        B_BE,
  input  logic [31:0]       B_WDATA,
  output logic              A_GNT,
  output logic              B_GNT,
  output logic              A_RVALID,
  output logic              B_RVALID,
  output logic [31:0]       A_RDATA,
  output logic [31:0]       B_RDATA,
  output logic              M_CSN,
  output logic              M_WEN,
  output logic [AWIDTH-1:0] M_ADDR,
  output logic [3:0]        M_BE,
  output logic [31:0]       M_DI,
  input  logic [31:0]       M_DOUT
);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic        last_q, last_d;
  logic        rtag_vld_q, rtag_vld_d;
  logic        rtag_id_q, rtag_id_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        gnt_a, gnt_b;

  always_comb begin
    // A wins unless B also requests and A was the most recent winner.
    gnt_a = RSTn & A_REQ & (~B_REQ | (last_q == PORT_B));
    gnt_b = RSTn & B_REQ & ~gnt_a;

    M_CSN  = 1'b1;
    M_WEN  = 1'b1;
    M_ADDR = '0;
    M_BE   = '0;
    M_DI   = '0;
    if (gnt_a) begin
      M_CSN  = 1'b0;
      M_WEN  = ~A_WE;
      M_ADDR = A_ADDR;
      M_BE   = A_BE;
      M_DI   = A_WDATA;
    end else if (gnt_b) begin
      M_CSN  = 1'b0;
      M_WEN  = ~B_WE;
      M_ADDR = B_ADDR;
      M_BE   = B_BE;
      M_DI   = B_WDATA;
    end

    last_d = last_q;
    if (gnt_a)      last_d = PORT_A;
    else if (gnt_b) last_d = PORT_B;

    rtag_vld_d = (gnt_a & ~A_WE) | (gnt_b & ~B_WE);
    rtag_id_d  = gnt_b ? PORT_B : PORT_A;

    A_RVALID = rtag_vld_q & (rtag_id_q == PORT_A);
    B_RVALID = rtag_vld_q & (rtag_id_q == PORT_B);

    // Responding port sees SRAM data directly; its hold register captures it at the edge.
    a_rdata_d = A_RVALID ? M_DOUT : a_rdata_q;
    b_rdata_d = B_RVALID ? M_DOUT : b_rdata_q;
    A_RDATA   = a_rdata_d;
    B_RDATA   = b_rdata_d;

    A_GNT = gnt_a;
    B_GNT = gnt_b;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      last_q     <= PORT_B;
      rtag_vld_q <= 1'b0;
      rtag_id_q  <= PORT_A;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      last_q     <= last_d;
      rtag_vld_q <= rtag_vld_d;
      rtag_id_q  <= rtag_id_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural single-port SRAM model.
module tb_sram_arbiter;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        A_REQ, B_REQ, A_WE, B_WE;
  logic [11:0] A_ADDR, B_ADDR;
  logic [3:0]  A_BE, B_BE;
  logic [31:0] A_WDATA, B_WDATA;
  logic        A_GNT, B_GNT, A_RVALID, B_RVALID;
  logic [31:0] A_RDATA, B_RDATA;
  logic        M_CSN, M_WEN;
  logic [11:0] M_ADDR;
  logic [3:0]  M_BE;
  logic [31:0] M_DI;
  logic [31:0] M_DOUT = 32'h0;

  logic [31:0] mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = 12'h0;
  logic [31:0] pre_data = 32'h0;

  int nvec = 0;
  int nerr = 0;

  sram_arbiter #(.AWIDTH(12)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_WE(A_WE), .A_BE(A_BE), .A_WDATA(A_WDATA),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_WE(B_WE), .B_BE(B_BE), .B_WDATA(B_WDATA),
    .A_GNT(A_GNT), .B_GNT(B_GNT), .A_RVALID(A_RVALID), .B_RVALID(B_RVALID),
    .A_RDATA(A_RDATA), .B_RDATA(B_RDATA),
    .M_CSN(M_CSN), .M_WEN(M_WEN), .M_ADDR(M_ADDR), .M_BE(M_BE), .M_DI(M_DI),
    .M_DOUT(M_DOUT)
  );

  always #5 CLK = ~CLK;

  // SRAM: byte-masked write at the edge, registered read data.
  always @(posedge CLK) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (!M_CSN) begin
      if (!M_WEN) begin
        for (int i = 0; i < 4; i++)
          if (M_BE[i]) mem[M_ADDR][8*i +: 8] <= M_DI[8*i +: 8];
      end else begin
        M_DOUT <= mem[M_ADDR];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    step();
    pre_en = 1'b0;
  endtask

  task automatic idle();
    A_REQ = 0; A_WE = 0; A_ADDR = 0; A_BE = 0; A_WDATA = 0;
    B_REQ = 0; B_WE = 0; B_ADDR = 0; B_BE = 0; B_WDATA = 0;
  endtask

  task automatic test_reset();
    A_REQ = 1; A_ADDR = 12'd5; B_REQ = 1; B_ADDR = 12'd2;
    #1;
    nvec++; if (A_GNT !== 1'b0) begin nerr++; $display("FAIL rst_a_gnt: got %b want 0", A_GNT); end
    nvec++; if (B_GNT !== 1'b0) begin nerr++; $display("FAIL rst_b_gnt: got %b want 0", B_GNT); end
    nvec++; if (M_CSN !== 1'b1 || M_WEN !== 1'b1) begin nerr++; $display("FAIL rst_csn_wen: got %b%b want 11", M_CSN, M_WEN); end
    nvec++; if (M_ADDR !== 12'h0 || M_BE !== 4'h0 || M_DI !== 32'h0) begin nerr++; $display("FAIL rst_mbus: got %h %h %h want 0", M_ADDR, M_BE, M_DI); end
    nvec++; if (A_RVALID !== 1'b0 || B_RVALID !== 1'b0) begin nerr++; $display("FAIL rst_rvalid: got %b%b want 00", A_RVALID, B_RVALID); end
    nvec++; if (A_RDATA !== 32'h0 || B_RDATA !== 32'h0) begin nerr++; $display("FAIL rst_rdata: got %h %h want 0", A_RDATA, B_RDATA); end
    step();
    RSTn = 1'b1;
    #1;
    nvec++; if (A_GNT !== 1'b1 || B_GNT !== 1'b0) begin nerr++; $display("FAIL rst_first_tie: got %b%b want 10", A_GNT, B_GNT); end
    nvec++; if (M_ADDR !== 12'd5 || M_CSN !== 1'b0) begin nerr++; $display("FAIL rst_first_addr: got %h csn %b want 005 csn 0", M_ADDR, M_CSN); end
    step();
    idle();
    #1;
    nvec++; if (A_RVALID !== 1'b1 || A_RDATA !== 32'hDEADBEEF) begin nerr++; $display("FAIL rst_first_resp: got %b %h want 1 deadbeef", A_RVALID, A_RDATA); end
    step();
  endtask

  task automatic test_single_read();
    A_REQ = 1; A_ADDR = 12'd5; A_WE = 0;
    #1;
    nvec++; if (A_GNT !== 1'b1 || M_WEN !== 1'b1 || M_ADDR !== 12'd5) begin nerr++; $display("FAIL rd_gnt: got gnt %b wen %b addr %h want 1 1 005", A_GNT, M_WEN, M_ADDR); end
    step();
    idle();
    #1;
    nvec++; if (A_RVALID !== 1'b1) begin nerr++; $display("FAIL rd_rvalid: got %b want 1", A_RVALID); end
    nvec++; if (A_RDATA !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_rdata: got %h want deadbeef", A_RDATA); end
    nvec++; if (B_RVALID !== 1'b0) begin nerr++; $display("FAIL rd_b_rvalid: got %b want 0", B_RVALID); end
    step();
    #1;
    nvec++; if (A_RVALID !== 1'b0 || A_RDATA !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_hold: got %b %h want 0 deadbeef", A_RVALID, A_RDATA); end
  endtask

  task automatic test_byte_write();
    B_REQ = 1; B_WE = 1; B_ADDR = 12'd8; B_BE = 4'b0101; B_WDATA = 32'hAABBCCDD;
    #1;
    nvec++; if (B_GNT !== 1'b1 || M_WEN !== 1'b0 || M_BE !== 4'b0101 || M_DI !== 32'hAABBCCDD) begin nerr++; $display("FAIL wr_drive: got gnt %b wen %b be %b di %h want 1 0 0101 aabbccdd", B_GNT, M_WEN, M_BE, M_DI); end
    step();
    idle();
    A_REQ = 1; A_ADDR = 12'd8;
    #1;
    nvec++; if (B_RVALID !== 1'b0 || A_GNT !== 1'b1) begin nerr++; $display("FAIL wr_no_rvalid: got b_rvalid %b a_gnt %b want 0 1", B_RVALID, A_GNT); end
    step();
    idle();
    #1;
    nvec++; if (A_RVALID !== 1'b1 || A_RDATA !== 32'h11BB33DD) begin nerr++; $display("FAIL wr_merge: got %b %h want 1 11bb33dd", A_RVALID, A_RDATA); end
    nvec++; if (B_RVALID !== 1'b0) begin nerr++; $display("FAIL wr_b_rvalid: got %b want 0", B_RVALID); end
    step();
  endtask

  task automatic test_contention();
    // Lone B write (BE=0, no effect) leaves LAST=B so the first tie goes to A.
    B_REQ = 1; B_WE = 1; B_ADDR = 12'd100; B_BE = 4'b0000; B_WDATA = 32'hFFFFFFFF;
    step();
    idle();
    A_REQ = 1; A_ADDR = 12'd1; B_REQ = 1; B_ADDR = 12'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      nvec++; if (A_GNT !== (i % 2 == 0) || B_GNT !== (i % 2 == 1) || M_CSN !== 1'b0) begin nerr++; $display("FAIL cont_gnt%0d: got a %b b %b csn %b want a %b b %b csn 0", i, A_GNT, B_GNT, M_CSN, (i % 2 == 0), (i % 2 == 1)); end
      if (i == 0) begin
        nvec++; if (A_RVALID !== 1'b0 || B_RVALID !== 1'b0) begin nerr++; $display("FAIL cont_resp0: got %b%b want 00", A_RVALID, B_RVALID); end
      end else if (i % 2 == 1) begin
        nvec++; if (A_RVALID !== 1'b1 || B_RVALID !== 1'b0 || A_RDATA !== 32'h01010101) begin nerr++; $display("FAIL cont_resp%0d: got %b%b %h want 10 01010101", i, A_RVALID, B_RVALID, A_RDATA); end
      end else begin
        nvec++; if (B_RVALID !== 1'b1 || A_RVALID !== 1'b0 || B_RDATA !== 32'h02020202) begin nerr++; $display("FAIL cont_resp%0d: got %b%b %h want 01 02020202", i, A_RVALID, B_RVALID, B_RDATA); end
      end
      step();
    end
    idle();
    #1;
    nvec++; if (B_RVALID !== 1'b1 || A_RVALID !== 1'b0 || B_RDATA !== 32'h02020202) begin nerr++; $display("FAIL cont_last: got %b%b %h want 01 02020202", A_RVALID, B_RVALID, B_RDATA); end
    step();
  endtask

  task automatic test_back_to_back();
    B_REQ = 1; B_WE = 1; B_ADDR = 12'd3; B_BE = 4'b1111; B_WDATA = 32'h12345678;
    step();
    idle();
    A_REQ = 1; A_ADDR = 12'd3;
    #1;
    nvec++; if (A_GNT !== 1'b1) begin nerr++; $display("FAIL b2b_gnt: got %b want 1", A_GNT); end
    step();
    idle();
    #1;
    nvec++; if (A_RVALID !== 1'b1 || A_RDATA !== 32'h12345678) begin nerr++; $display("FAIL b2b_data: got %b %h want 1 12345678", A_RVALID, A_RDATA); end
    step();
  endtask

  task automatic test_reset_mid_read();
    A_REQ = 1; A_ADDR = 12'd5;
    #1;
    nvec++; if (A_GNT !== 1'b1) begin nerr++; $display("FAIL mid_gnt: got %b want 1", A_GNT); end
    @(posedge CLK);
    #1;
    RSTn = 1'b0;
    idle();
    #1;
    nvec++; if (A_RVALID !== 1'b0 || A_RDATA !== 32'h0) begin nerr++; $display("FAIL mid_clear: got %b %h want 0 00000000", A_RVALID, A_RDATA); end
    @(negedge CLK);
    step();
    RSTn = 1'b1;
    A_REQ = 1; A_ADDR = 12'd1; B_REQ = 1; B_ADDR = 12'd2;
    #1;
    nvec++; if (A_RVALID !== 1'b0 || A_RDATA !== 32'h0) begin nerr++; $display("FAIL mid_post: got %b %h want 0 00000000", A_RVALID, A_RDATA); end
    nvec++; if (A_GNT !== 1'b1 || B_GNT !== 1'b0) begin nerr++; $display("FAIL mid_tie: got %b%b want 10", A_GNT, B_GNT); end
    step();
    idle();
    #1;
    nvec++; if (A_RVALID !== 1'b1 || A_RDATA !== 32'h01010101) begin nerr++; $display("FAIL mid_resp: got %b %h want 1 01010101", A_RVALID, A_RDATA); end
    step();
  endtask

  initial begin
    RSTn = 1'b0;
    idle();
    preload(12'd5, 32'hDEADBEEF);
    preload(12'd8, 32'h11223344);
    preload(12'd1, 32'h01010101);
    preload(12'd2, 32'h02020202);
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
